param_sync_ram: RTL
===================

// Module: param_sync_ram
// PURPOSE
//  Parametrised single-port synchronous RAM; next generation of the 256x16 CPU memory.
//  - Adds a valid/ready request port, a configurable read pipeline latency with rd_valid,
//    a post-reset clear sweep and out-of-range address detection.
//  - Sits between the CPU datapath/loader and storage; serves as both program and data RAM.
// PARAMETERS
//  DATA_W      16   data word width, bits
//  ADDR_W      8    address width, bits
//  DEPTH       256  number of words, 1..2**ADDR_W
//  READ_LAT    1    accept-to-rd_valid latency, cycles: 1 or 2 (2 adds output register)
//  INIT_CLEAR  1    1: zero every word after reset; 0: contents retained across reset
// PORTS
//  clk        in   1       clock, all logic on rising edge
//  rst        in   1       asynchronous, active-high reset
//  req_valid  in   1       request present
//  req_write  in   1       1 = write, 0 = read; sampled with req_valid
//  req_addr   in   ADDR_W  word address
//  req_wdata  in   DATA_W  write data
//  req_ready  out  1       request accepted this cycle when req_valid & req_ready
//  rd_valid   out  1       one-cycle pulse per accepted read; rd_data valid this cycle
//  rd_data    out  DATA_W  read data; holds last value while rd_valid = 0
//  addr_err   out  1       one-cycle pulse, READ_LAT after an accepted out-of-range request
//  busy       out  1       clear sweep in progress
// BEHAVIOUR
//  Reset (async, immediate):
//  - rd_valid = 0, addr_err = 0, rd_data = 0; read pipeline flushed; sweep counter = 0.
//  - busy = INIT_CLEAR; req_ready = ~busy.
//  FSM states: CLEAR, RUN.
//  - State after rst: CLEAR if INIT_CLEAR, else RUN.
//  - CLEAR: writes mem[cnt] = 0, cnt++ each cycle; after cnt = DEPTH-1 is written, go to RUN.
//    Exactly DEPTH cycles. busy = 1 and req_ready = 0 throughout; req_* ignored.
//  - RUN: busy = 0, req_ready = 1 every cycle; no return to CLEAR except via rst.
//  Accept = req_valid & req_ready at a rising edge.
//  Write accept: mem[req_addr] = req_wdata at that edge; no rd_valid pulse.
//  Read accept at edge E:
//  - READ_LAT = 1: rd_valid = 1 and rd_data = mem[addr] in cycle after E.
//  - READ_LAT = 2: same, one cycle later.
//  - One request per cycle; back-to-back reads give back-to-back rd_valid pulses, in order.
//  Ordering: a read accepted the cycle after a write to the same address returns new data.
//  Out of range (req_addr >= DEPTH):
//  - Write dropped. Read returns rd_data = 0 with rd_valid = 1.
//  - addr_err pulses aligned with where rd_valid would be, for both reads and writes.
//  Reset mid-operation:
//  - In-flight reads discarded; no rd_valid after rst.
//  - With INIT_CLEAR = 1 the sweep restarts at 0; with 0, contents retained.
//  req_* X during RUN with req_valid = 0: no effect on memory or outputs.
// TESTING (DATA_W=16, ADDR_W=8, READ_LAT=1 unless noted)
//  1. DEPTH=256, INIT_CLEAR=1, rst pulse:
//     -> busy high exactly 256 cycles, req_ready = 0 throughout.
//     -> reads of 0x00, 0x7F, 0xFF then return 0x0000.
//  2. Write 0x01=0x0001, 0x02=0x0002, 0xAA=0xAAAA, 0xBB=0xBBBB, 0xCC=0xCCCC;
//     back-to-back reads of the same addresses:
//     -> 5 consecutive rd_valid pulses, data in order, each 1 cycle after accept.
//  3. Write 0x10=0x1234, then read 0x10 the next cycle -> rd_data = 0x1234.
//     Repeat with READ_LAT=2 -> data arrives 2 cycles after accept.
//  4. DEPTH=200:
//     -> write 0xC8=0xFFFF: addr_err pulse, memory unchanged.
//     -> read 0xC8: rd_valid with 0x0000 plus addr_err.
//     -> read 0xC7: valid, no addr_err.
//  5. Issue read 0x01, assert rst mid-cycle before rd_valid:
//     -> rd_valid never pulses; busy rises immediately; sweep restarts from 0.
//  6. INIT_CLEAR=0: write 0x55=0xBEEF, pulse rst
//     -> busy stays 0, req_ready = 1 the first cycle after rst, read 0x55 = 0xBEEF.

Source files
------------

// File: rtl/param_sync_ram.sv
// Parametrised single-port synchronous RAM with valid/ready request port,
// 1- or 2-cycle read latency, optional post-reset clear sweep and range checking.
module param_sync_ram #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 8,
    parameter int DEPTH      = 256,
    parameter int READ_LAT   = 1,
    parameter int INIT_CLEAR = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              req_ready,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              addr_err,
    output logic              busy
);

    typedef enum logic {ST_CLEAR, ST_RUN} state_t;

    localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic              accept, in_range;
    logic              s0_valid, s0_err;
    logic [DATA_W-1:0] s0_data;
    logic              src_valid, src_err;
    logic [DATA_W-1:0] src_data;
    logic              rd_valid_q, rd_valid_d;
    logic              addr_err_q, addr_err_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;

    assign busy      = (state_q == ST_CLEAR);
    assign req_ready = ~busy;
    assign accept    = req_valid & req_ready;
    assign in_range  = ({1'b0, req_addr} < DEPTH_EXT);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mem_we    = 1'b0;
        mem_waddr = req_addr;
        mem_wdata = req_wdata;
        case (state_q)
            ST_CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = cnt_q;
                mem_wdata = '0;
                if (cnt_q == LAST_ADDR) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + ADDR_W'(1);
                end
            end
            default: mem_we = accept & req_write & in_range;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= (INIT_CLEAR != 0) ? ST_CLEAR : ST_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Storage is deliberately not reset so contents survive reset when INIT_CLEAR = 0.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    always_comb begin
        s0_valid = accept & ~req_write;
        s0_err   = accept & ~in_range;
        s0_data  = in_range ? mem[req_addr] : '0;
    end

    if (READ_LAT == 2) begin : g_lat2
        logic              p1_valid_q, p1_err_q;
        logic [DATA_W-1:0] p1_data_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                p1_valid_q <= 1'b0;
                p1_err_q   <= 1'b0;
                p1_data_q  <= '0;
            end else begin
                p1_valid_q <= s0_valid;
                p1_err_q   <= s0_err;
                p1_data_q  <= s0_data;
            end
        end

        assign src_valid = p1_valid_q;
        assign src_err   = p1_err_q;
        assign src_data  = p1_data_q;
    end else begin : g_lat1
        assign src_valid = s0_valid;
        assign src_err   = s0_err;
        assign src_data  = s0_data;
    end

    always_comb begin
        rd_valid_d = src_valid;
        addr_err_d = src_err;
        rd_data_d  = src_valid ? src_data : rd_data_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_valid_q <= 1'b0;
            addr_err_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_valid_q <= rd_valid_d;
            addr_err_q <= addr_err_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign rd_valid = rd_valid_q;
    assign addr_err = addr_err_q;
    assign rd_data  = rd_data_q;

endmodule
